// File: rtl/pipe_pkg.sv
// Shared pipeline control types: controller state, the wen/flush bundle
// that pipeline register wrappers consume, and default drain depth.
package pipe_pkg;

    localparam int REG_W            = 4;
    localparam int DRAIN_CYCLES_DEF = 3;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        DSTALL  = 2'd1,
        HALTING = 2'd2,
        HALTED  = 2'd3
    } pipe_state_t;

    typedef struct packed {
        logic pc_wen;
        logic fd_wen;
        logic dx_wen;
        logic xm_wen;
        logic mw_wen;
        logic fd_flush;
        logic dx_flush;
        logic mw_flush;
    } pipe_ctrl_t;

    // A flushed register still needs its wen set so the zero gets loaded.
    localparam pipe_ctrl_t CTRL_RUN   = pipe_ctrl_t'(8'b11111_000);
    localparam pipe_ctrl_t CTRL_DMISS = pipe_ctrl_t'(8'b00001_001);
    localparam pipe_ctrl_t CTRL_IDLE  = pipe_ctrl_t'(8'b00000_000);
    localparam pipe_ctrl_t CTRL_RESET = pipe_ctrl_t'(8'b00000_111);

endpackage

// File: rtl/pipeline_ctrl_hazard_detect.sv
// Load-use compare: decode sources against a pending load in D/X.
module hazard_detect
    import pipe_pkg::*;
(
    input  logic [REG_W-1:0] d_src1,
    input  logic [REG_W-1:0] d_src2,
    input  logic             d_uses_src1,
    input  logic             d_uses_src2,
    input  logic [REG_W-1:0] x_reg_dest,
    input  logic             x_mem_read,
    input  logic             x_reg_write,
    output logic             load_use
);

    // r0 is hardwired zero, so a load targeting it never produces a value.
    assign load_use = x_mem_read && x_reg_write && (x_reg_dest != '0) &&
                      ((d_uses_src1 && (d_src1 == x_reg_dest)) ||
                       (d_uses_src2 && (d_src2 == x_reg_dest)));

endmodule

// File: rtl/pipeline_ctrl.sv
// Stall/flush controller for the 5-stage pipe: hazards, branch squash,
// cache-miss freeze and halt drain sequencing.
module pipeline_ctrl
    import pipe_pkg::*;
#(
    parameter int DRAIN_CYCLES = DRAIN_CYCLES_DEF,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       d_src1,
    input  logic [3:0]       d_src2,
    input  logic             d_uses_src1,
    input  logic             d_uses_src2,
    input  logic             d_halt,
    input  logic [3:0]       x_reg_dest,
    input  logic             x_MemRead,
    input  logic             x_RegWrite,
    input  logic             x_branch_taken,
    input  logic             icache_miss,
    input  logic             dcache_miss,
    output logic             pc_wen,
    output logic             fd_wen,
    output logic             dx_wen,
    output logic             xm_wen,
    output logic             mw_wen,
    output logic             fd_flush,
    output logic             dx_flush,
    output logic             mw_flush,
    output logic             halted,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam int DRAIN_W = (DRAIN_CYCLES < 2) ? 1 : $clog2(DRAIN_CYCLES + 1);

    pipe_state_t        state, state_nxt, run_nxt;
    logic [DRAIN_W-1:0] drain_cnt, cnt_nxt;
    pipe_ctrl_t         run_ctrl, ctrl, ctrl_out;
    logic               run_load, halted_c, load_use;

    hazard_detect u_hazard (
        .d_src1      (d_src1),
        .d_src2      (d_src2),
        .d_uses_src1 (d_uses_src1),
        .d_uses_src2 (d_uses_src2),
        .x_reg_dest  (x_reg_dest),
        .x_mem_read  (x_MemRead),
        .x_reg_write (x_RegWrite),
        .load_use    (load_use)
    );

    // Normal-flow decision, also reused on the cycle a D-miss resolves.
    always_comb begin
        run_ctrl = CTRL_RUN;
        run_nxt  = RUN;
        run_load = 1'b0;
        if (dcache_miss) begin
            run_ctrl = CTRL_DMISS;
            run_nxt  = DSTALL;
        end else if (x_branch_taken) begin
            run_ctrl.fd_flush = 1'b1;
            run_ctrl.dx_flush = 1'b1;
        end else if (load_use) begin
            run_ctrl.pc_wen   = 1'b0;
            run_ctrl.fd_wen   = 1'b0;
            run_ctrl.dx_flush = 1'b1;
        end else if (d_halt) begin
            run_ctrl.pc_wen   = 1'b0;
            run_ctrl.fd_flush = 1'b1;
            run_nxt           = HALTING;
            run_load          = 1'b1;
        end else if (icache_miss) begin
            run_ctrl.pc_wen   = 1'b0;
            run_ctrl.fd_flush = 1'b1;
        end
    end

    always_comb begin
        ctrl      = run_ctrl;
        state_nxt = run_nxt;
        cnt_nxt   = run_load ? DRAIN_W'(DRAIN_CYCLES) : drain_cnt;
        halted_c  = 1'b0;
        case (state)
            RUN: ;
            DSTALL: begin
                if (dcache_miss) begin
                    ctrl      = CTRL_DMISS;
                    state_nxt = DSTALL;
                    cnt_nxt   = drain_cnt;
                end
            end
            HALTING: begin
                ctrl          = CTRL_RUN;
                ctrl.pc_wen   = 1'b0;
                ctrl.fd_flush = 1'b1;
                state_nxt     = HALTING;
                cnt_nxt       = drain_cnt;
                if (dcache_miss) begin
                    // X/M waits on the fill, so M/W takes a bubble behind it.
                    ctrl.dx_wen   = 1'b0;
                    ctrl.xm_wen   = 1'b0;
                    ctrl.mw_flush = 1'b1;
                end else if (drain_cnt <= DRAIN_W'(1)) begin
                    cnt_nxt   = '0;
                    state_nxt = HALTED;
                end else begin
                    cnt_nxt = drain_cnt - DRAIN_W'(1);
                end
            end
            HALTED: begin
                ctrl      = CTRL_IDLE;
                state_nxt = HALTED;
                cnt_nxt   = drain_cnt;
                halted_c  = 1'b1;
            end
            default: state_nxt = RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= RUN;
            drain_cnt <= '0;
            stall_cnt <= '0;
        end else begin
            state     <= state_nxt;
            drain_cnt <= cnt_nxt;
            if (!ctrl.pc_wen && (state != HALTED) && (stall_cnt != '1))
                stall_cnt <= stall_cnt + 1'b1;
        end
    end

    assign ctrl_out = rst ? ctrl : CTRL_RESET;
    assign halted   = rst & halted_c;

    assign pc_wen   = ctrl_out.pc_wen;
    assign fd_wen   = ctrl_out.fd_wen;
    assign dx_wen   = ctrl_out.dx_wen;
    assign xm_wen   = ctrl_out.xm_wen;
    assign mw_wen   = ctrl_out.mw_wen;
    assign fd_flush = ctrl_out.fd_flush;
    assign dx_flush = ctrl_out.dx_flush;
    assign mw_flush = ctrl_out.mw_flush;

endmodule
